// File: rtl/util_fir_dec.sv
// Two-channel I/Q rate reducer: 16-tap symmetric low-pass FIR plus decimation, or a registered bypass.
// Build option: define UTIL_FIR_DEC_ROUND_EN to round half up before the Q15 shift; otherwise the result is truncated.
module util_fir_dec #(
  parameter int DEC_FACTOR = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      s_axis_data_tvalid,
  output logic                      s_axis_data_tready,
  input  logic [DATA_WIDTH-1:0]     channel_0,
  input  logic [DATA_WIDTH-1:0]     channel_1,
  input  logic                      decimate,
  output logic                      m_axis_data_tvalid,
  output logic [2*DATA_WIDTH-1:0]   m_axis_data_tdata
);

  localparam int TAPS  = 16;
  localparam int ACC_W = 37;
  localparam int PH_W  = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;

  function automatic logic signed [15:0] coef(input int k);
    case (k)
      0, 15:   return 16'sd256;
      1, 14:   return 16'sd512;
      2, 13:   return 16'sd1024;
      3, 12:   return 16'sd1536;
      4, 11:   return 16'sd2304;
      5, 10:   return 16'sd3072;
      6, 9:    return 16'sd3584;
      default: return 16'sd4096;
    endcase
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] rnd_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] a;
    logic signed [ACC_W-1:0] s;
    a = acc;
`ifdef UTIL_FIR_DEC_ROUND_EN
    a = acc + ACC_W'(16384);
`endif
    s = a >>> 15;
    if (s > ACC_W'(32767))
      return 16'sh7fff;
    else if (s < -ACC_W'(32768))
      return 16'sh8000;
    else
      return s[DATA_WIDTH-1:0];
  endfunction

  logic                          tready_q;
  logic                          dec_p0;
  logic [PH_W-1:0]               phase_p0;
  logic signed [DATA_WIDTH-1:0]  x0_p0 [TAPS];
  logic signed [DATA_WIDTH-1:0]  x1_p0 [TAPS];
  logic                          vld_p0;
  logic                          vld_p1;
  logic [2*DATA_WIDTH-1:0]       tdata_p1;

  logic                          accept;
  logic                          mode_chg;
  logic signed [ACC_W-1:0]       acc0;
  logic signed [ACC_W-1:0]       acc1;
  logic signed [31:0]            prod0;
  logic signed [31:0]            prod1;
  logic signed [DATA_WIDTH-1:0]  y0;
  logic signed [DATA_WIDTH-1:0]  y1;

  assign accept   = s_axis_data_tvalid & tready_q;
  assign mode_chg = (decimate != dec_p0);

  // Stage p0 -> p1: full 16-tap MAC over the current delay line
  always_comb begin
    acc0  = '0;
    acc1  = '0;
    prod0 = '0;
    prod1 = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod0 = 32'(x0_p0[k]) * 32'(coef(k));
      prod1 = 32'(x1_p0[k]) * 32'(coef(k));
      acc0  = acc0 + ACC_W'(prod0);
      acc1  = acc1 + ACC_W'(prod1);
    end
    y0 = rnd_sat(acc0);
    y1 = rnd_sat(acc1);
  end

  // Stage p0: delay lines, phase counter and compute flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tready_q <= 1'b0;
      dec_p0   <= 1'b0;
      phase_p0 <= '0;
      vld_p0   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x0_p0[k] <= '0;
        x1_p0[k] <= '0;
      end
    end else begin
      tready_q <= 1'b1;
      dec_p0   <= decimate;
      vld_p0   <= 1'b0;
      if (mode_chg) begin
        // A sample accepted on the switch edge becomes the first entry of the fresh line
        for (int k = 1; k < TAPS; k++) begin
          x0_p0[k] <= '0;
          x1_p0[k] <= '0;
        end
        x0_p0[0] <= (accept && decimate) ? channel_0 : '0;
        x1_p0[0] <= (accept && decimate) ? channel_1 : '0;
        phase_p0 <= (accept && decimate) ? PH_W'(1) : '0;
      end else if (accept && decimate) begin
        for (int k = 1; k < TAPS; k++) begin
          x0_p0[k] <= x0_p0[k-1];
          x1_p0[k] <= x1_p0[k-1];
        end
        x0_p0[0] <= channel_0;
        x1_p0[0] <= channel_1;
        phase_p0 <= phase_p0 + 1'b1;
        vld_p0   <= (phase_p0 == PH_W'(DEC_FACTOR - 1));
      end
    end
  end

  // Stage p1: output register; a flagged filter result takes precedence over a bypass sample
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (vld_p0) begin
        tdata_p1 <= {y1, y0};
        vld_p1   <= 1'b1;
      end else if (accept && !decimate) begin
        tdata_p1 <= {channel_1, channel_0};
        vld_p1   <= 1'b1;
      end
    end
  end

  assign s_axis_data_tready = tready_q;
  assign m_axis_data_tvalid = vld_p1;
  assign m_axis_data_tdata  = tdata_p1;

endmodule

// File: tb/tb_util_fir_dec.sv
// Self-checking bench for util_fir_dec: directed scenarios plus a randomized run against a queue-based FIR model.
module tb_util_fir_dec;

  localparam int DEC = 8;
`ifdef UTIL_FIR_DEC_ROUND_EN
  localparam logic [31:0] RND_EXP  = 32'h0002_0002;
  localparam logic [31:0] MODE_EXP = 32'h1111_0889;
`else
  localparam logic [31:0] RND_EXP  = 32'h0001_0001;
  localparam logic [31:0] MODE_EXP = 32'h1111_0888;
`endif

  logic        aclk;
  logic        aresetn;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] ch0;
  logic [15:0] ch1;
  logic        decimate;
  logic        m_tvalid;
  logic [31:0] m_tdata;

  util_fir_dec #(.DEC_FACTOR(DEC), .DATA_WIDTH(16)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .channel_0          (ch0),
    .channel_1          (ch1),
    .decimate           (decimate),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tdata  (m_tdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  int coefs [16] = '{256, 512, 1024, 1536, 2304, 3072, 3584, 4096,
                     4096, 3584, 3072, 2304, 1536, 1024, 512, 256};

  // Reference model state: sample history since last clear (newest first)
  int          q0[$];
  int          q1[$];
  int          ph;
  bit          mready;
  bit          mdec;
  bit          pend_v;
  logic [31:0] pend_d;
  bit          exp_v;
  logic [31:0] exp_d;
  logic [31:0] outs[$];

  function automatic logic [15:0] fir_ch(input int ch);
    int q[$];
    longint acc;
    logic [15:0] r;
    if (ch == 1) q = q1; else q = q0;
    acc = 0;
    for (int k = 0; k < q.size() && k < 16; k++)
      acc += longint'(coefs[k]) * longint'(q[k]);
`ifdef UTIL_FIR_DEC_ROUND_EN
    acc += 16384;
`endif
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    r = acc[15:0];
    return r;
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    ph = 0; mready = 0; mdec = 0;
    pend_v = 0; pend_d = '0; exp_v = 0; exp_d = '0;
  endtask

  task automatic drive_cycle(input bit v, input logic [15:0] c0, input logic [15:0] c1, input bit dec);
    bit acc;
    s_tvalid = v; ch0 = c0; ch1 = c1; decimate = dec;
    @(posedge aclk); #1;
    acc    = v && mready;
    mready = 1;
    exp_v  = pend_v;
    if (pend_v) exp_d = pend_d;
    pend_v = 0;
    if (dec != mdec) begin
      q0.delete(); q1.delete(); ph = 0;
    end
    mdec = dec;
    if (acc && !dec && !exp_v) begin
      exp_v = 1;
      exp_d = {c1, c0};
    end
    if (acc && dec) begin
      q0.push_front(int'($signed(c0)));
      q1.push_front(int'($signed(c1)));
      if (q0.size() > 16) begin
        void'(q0.pop_back());
        void'(q1.pop_back());
      end
      ph++;
      if (ph == DEC) begin
        ph     = 0;
        pend_v = 1;
        pend_d = {fir_ch(1), fir_ch(0)};
      end
    end
    if (m_tvalid === 1'b1) outs.push_back(m_tdata);
  endtask

  task automatic reset_assert();
    #2;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    #1;
  endtask

  task automatic reset_release();
    model_reset();
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    outs.delete();
  endtask

  task automatic do_reset();
    reset_assert();
    reset_release();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_tvalid = 0; ch0 = 0; ch1 = 0; decimate = 0;
    model_reset();
    @(posedge aclk); #1;
    checks++;
    if ({s_tready, m_tvalid, m_tdata} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: tready=%0b tvalid=%0b tdata=%h, expected all zero", s_tready, m_tvalid, m_tdata);
    end
    reset_release();
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL tready_before_edge: got %0b, expected 0", s_tready);
    end
    drive_cycle(0, 16'h0, 16'h0, 0);
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL tready_after_edge: tready=%0b tvalid=%0b, expected 1/0", s_tready, m_tvalid);
    end
  endtask

  task automatic test_direct();
    do_reset();
    drive_cycle(0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 14; i++) begin
      drive_cycle(i < 10, 16'h2000, 16'h4000, 0);
      checks++;
      if (m_tvalid !== exp_v || m_tdata !== exp_d) begin
        errors++;
        $display("FAIL direct cycle %0d: tvalid=%0b tdata=%h, expected tvalid=%0b tdata=%h", i, m_tvalid, m_tdata, exp_v, exp_d);
      end
    end
    checks++;
    if (outs.size() != 10) begin
      errors++;
      $display("FAIL direct_count: got %0d outputs, expected 10", outs.size());
    end
    foreach (outs[i]) begin
      checks++;
      if (outs[i] !== 32'h4000_2000) begin
        errors++;
        $display("FAIL direct_data %0d: got %h, expected 40002000", i, outs[i]);
      end
    end
  endtask

  task automatic test_dc_decimation();
    do_reset();
    drive_cycle(0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 35; i++) begin
      drive_cycle(i < 32, 16'h1000, 16'hF000, 1);
      checks++;
      if (m_tvalid !== exp_v || m_tdata !== exp_d) begin
        errors++;
        $display("FAIL dc cycle %0d: tvalid=%0b tdata=%h, expected tvalid=%0b tdata=%h", i, m_tvalid, m_tdata, exp_v, exp_d);
      end
    end
    checks++;
    if (outs.size() != 4) begin
      errors++;
      $display("FAIL dc_count: got %0d outputs, expected 4", outs.size());
    end else begin
      checks++;
      if (outs[0] !== 32'hF800_0800) begin
        errors++;
        $display("FAIL dc_first: got %h, expected F8000800", outs[0]);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (outs[i] !== 32'hF000_1000) begin
          errors++;
          $display("FAIL dc_steady %0d: got %h, expected F0001000", i, outs[i]);
        end
      end
    end
  endtask

  task automatic test_rounding();
    do_reset();
    drive_cycle(0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 12; i++) begin
      drive_cycle(i < 8, 16'h0003, 16'h0003, 1);
      checks++;
      if (m_tvalid !== exp_v || m_tdata !== exp_d) begin
        errors++;
        $display("FAIL round cycle %0d: tvalid=%0b tdata=%h, expected tvalid=%0b tdata=%h", i, m_tvalid, m_tdata, exp_v, exp_d);
      end
    end
    checks++;
    if (outs.size() != 1 || outs[0] !== RND_EXP) begin
      errors++;
      $display("FAIL round_result: got %0d outputs first=%h, expected 1 output %h", outs.size(), (outs.size() > 0) ? outs[0] : 32'h0, RND_EXP);
    end
  endtask

  task automatic test_mode_switch();
    bit dseq [3] = '{1'b1, 1'b0, 1'b1};
    drive_cycle(0, 16'h0, 16'h0, 0);
    outs.delete();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 12; i++) begin
        drive_cycle(i >= 1 && i <= 8, 16'h1111, 16'h2222, dseq[p]);
        checks++;
        if (m_tvalid !== exp_v || m_tdata !== exp_d) begin
          errors++;
          $display("FAIL mode phase %0d cycle %0d: tvalid=%0b tdata=%h, expected tvalid=%0b tdata=%h", p, i, m_tvalid, m_tdata, exp_v, exp_d);
        end
      end
    end
    checks++;
    if (outs.size() != 10) begin
      errors++;
      $display("FAIL mode_count: got %0d outputs, expected 10", outs.size());
    end else begin
      foreach (outs[i]) begin
        checks++;
        if (outs[i] !== ((i == 0 || i == 9) ? MODE_EXP : 32'h2222_1111)) begin
          errors++;
          $display("FAIL mode_data %0d: got %h, expected %h", i, outs[i], (i == 0 || i == 9) ? MODE_EXP : 32'h2222_1111);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive_cycle(0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 5; i++)
      drive_cycle(1, 16'($urandom), 16'($urandom), 1);
    reset_assert();
    checks++;
    if ({s_tready, m_tvalid, m_tdata} !== 34'd0) begin
      errors++;
      $display("FAIL midreset_outputs: tready=%0b tvalid=%0b tdata=%h, expected all zero", s_tready, m_tvalid, m_tdata);
    end
    reset_release();
    drive_cycle(0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 11; i++) begin
      drive_cycle(i < 8, 16'h1000, 16'h0800, 1);
      checks++;
      if (m_tvalid !== exp_v || m_tdata !== exp_d) begin
        errors++;
        $display("FAIL midreset cycle %0d: tvalid=%0b tdata=%h, expected tvalid=%0b tdata=%h", i, m_tvalid, m_tdata, exp_v, exp_d);
      end
    end
    checks++;
    if (outs.size() != 1 || outs[0] !== 32'h0400_0800) begin
      errors++;
      $display("FAIL midreset_result: got %0d outputs first=%h, expected 1 output 04000800", outs.size(), (outs.size() > 0) ? outs[0] : 32'h0);
    end
    do_reset();
    drive_cycle(0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 11; i++)
      drive_cycle(i < 8, 16'h1000, 16'h1000, 1);
    checks++;
    if (outs.size() != 1 || outs[0] !== 32'h0800_0800) begin
      errors++;
      $display("FAIL midreset_spec: got %0d outputs first=%h, expected 1 output 08000800", outs.size(), (outs.size() > 0) ? outs[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    bit          dec;
    bit          v;
    logic [15:0] a;
    logic [15:0] b;
    dec = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      if (!v && $urandom_range(0, 29) == 0) dec = ~dec;
      case ($urandom_range(0, 7))
        0:       begin a = 16'h7FFF; b = 16'h8000; end
        1:       begin a = 16'h8000; b = 16'h7FFF; end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      drive_cycle(v, a, b, dec);
      checks++;
      if (m_tvalid !== exp_v || m_tdata !== exp_d) begin
        errors++;
        $display("FAIL random cycle %0d: tvalid=%0b tdata=%h, expected tvalid=%0b tdata=%h", i, m_tvalid, m_tdata, exp_v, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_dc_decimation();
    test_rounding();
    test_mode_switch();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
